// File: rtl/whac_a_mole_game_ctrl.sv
// whac_a_mole_game_ctrl: multi-slot whac-a-mole game controller.
// Ports: clk, reset (sync, active-high); start/level_sel/abort control
// the game; rng_value/rng_valid/rng_req fetch random mole indices;
// toggle_switches are the raw board switches; mole_leds, points,
// lives_left, multiplier, level_number, playing, game_over report status.
module whac_a_mole_game_ctrl #(
   parameter int NUM_MOLES   = 18,
   parameter int MAX_ACTIVE  = 3,
   parameter int LIVES       = 3,
   parameter int POINTS_W    = 16,
   parameter int TIMER_W     = 28,
   parameter int TIMEOUT_L1  = 100000000,
   parameter int TIMEOUT_L2  = 50000000,
   parameter int TIMEOUT_L3  = 25000000,
   parameter int STREAK_STEP = 10,
   parameter int MAX_MULT    = 8,
   localparam int IDX_W      = $clog2(NUM_MOLES),
   localparam int LIVE_W     = $clog2(LIVES + 1),
   localparam int MULT_W     = $clog2(MAX_MULT) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           level_sel,
   input  logic                 abort,
   input  logic [IDX_W-1:0]     rng_value,
   input  logic                 rng_valid,
   input  logic [NUM_MOLES-1:0] toggle_switches,
   output logic                 rng_req,
   output logic [NUM_MOLES-1:0] mole_leds,
   output logic [POINTS_W-1:0]  points,
   output logic [LIVE_W-1:0]    lives_left,
   output logic [MULT_W-1:0]    multiplier,
   output logic [1:0]           level_number,
   output logic                 playing,
   output logic                 game_over
);

   localparam int CNT_W = $clog2(MAX_ACTIVE + 1);
   localparam int STK_W = $clog2(STREAK_STEP + MAX_ACTIVE + 1);
   localparam int ADD_W = POINTS_W + 1;
   localparam int CAP2  = (MAX_ACTIVE < 2) ? MAX_ACTIVE : 2;

   typedef enum logic [1:0] { IDLE, PLAY, OVER } state_t;

   state_t state, state_n;

   logic [MAX_ACTIVE-1:0] vld, vld_n;
   logic [IDX_W-1:0]      idx   [MAX_ACTIVE];
   logic [IDX_W-1:0]      idx_n [MAX_ACTIVE];
   logic [TIMER_W-1:0]    tmr   [MAX_ACTIVE];
   logic [TIMER_W-1:0]    tmr_n [MAX_ACTIVE];

   logic [NUM_MOLES-1:0] leds_n;
   logic [POINTS_W-1:0]  points_n;
   logic [LIVE_W-1:0]    lives_n;
   logic [MULT_W-1:0]    mult_n;
   logic [1:0]           level_n;
   // streak is kept modulo STREAK_STEP; only crossings matter
   logic [STK_W-1:0]     streak, streak_n;

   logic [NUM_MOLES-1:0] sw_s1, sw_s2, sw_prev, toggle;

   logic [CNT_W-1:0]      occ, cap, n_hit, n_exp;
   logic [MAX_ACTIVE-1:0] hit, expd, fsel;
   logic [NUM_MOLES-1:0]  rng_dec;
   logic [TIMER_W-1:0]    tout;
   logic                  wrong, spawn;
   logic [ADD_W-1:0]      psum;
   logic [STK_W-1:0]      ssum;
   logic [MULT_W-1:0]     mdbl;

   always_ff @(posedge clk) begin
      sw_s1   <= toggle_switches;
      sw_s2   <= sw_s1;
      sw_prev <= sw_s2;
   end

   assign toggle = sw_s2 ^ sw_prev;

   always_comb begin
      occ   = '0;
      n_hit = '0;
      n_exp = '0;
      hit   = '0;
      expd  = '0;
      fsel  = '0;
      for (int s = 0; s < MAX_ACTIVE; s++) begin
         // a hit on the expiry cycle wins over the timeout
         hit[s]  = vld[s] && toggle[idx[s]];
         expd[s] = vld[s] && !hit[s] &&
                   (tmr[s] == TIMER_W'(1));
         occ   = occ + CNT_W'(vld[s]);
         n_hit = n_hit + CNT_W'(hit[s]);
         n_exp = n_exp + CNT_W'(expd[s]);
         if (!vld[s] && fsel == '0)
            fsel[s] = 1'b1;
      end
   end

   // out-of-range rng values decode to all zeros
   always_comb begin
      rng_dec = '0;
      for (int i = 0; i < NUM_MOLES; i++)
         rng_dec[i] = (rng_value == IDX_W'(i));
   end

   always_comb begin
      unique case (level_number)
         2'd1: begin
            cap  = CNT_W'(1);
            tout = TIMER_W'(TIMEOUT_L1);
         end
         2'd2: begin
            cap  = CNT_W'(CAP2);
            tout = TIMER_W'(TIMEOUT_L2);
         end
         default: begin
            cap  = CNT_W'(MAX_ACTIVE);
            tout = TIMER_W'(TIMEOUT_L3);
         end
      endcase
   end

   assign playing   = (state == PLAY);
   assign game_over = (state == OVER);
   assign rng_req   = playing && (occ < cap);
   assign wrong     = |(toggle & ~mole_leds);
   assign spawn     = rng_req && rng_valid &&
                      |(rng_dec & ~mole_leds);

   assign psum = {1'b0, points} +
                 ADD_W'(n_hit) * ADD_W'(multiplier);
   assign ssum = streak + STK_W'(n_hit);
   assign mdbl = (multiplier >= MULT_W'(MAX_MULT / 2)) ?
                 MULT_W'(MAX_MULT) : (multiplier << 1);

   always_comb begin
      state_n  = state;
      vld_n    = vld;
      idx_n    = idx;
      tmr_n    = tmr;
      points_n = points;
      lives_n  = lives_left;
      mult_n   = multiplier;
      level_n  = level_number;
      streak_n = streak;
      if (abort) begin
         state_n = IDLE;
         vld_n   = '0;
      end else begin
         unique case (state)
            PLAY: begin
               for (int s = 0; s < MAX_ACTIVE; s++) begin
                  if (hit[s] || expd[s])
                     vld_n[s] = 1'b0;
                  else if (vld[s])
                     tmr_n[s] = tmr[s] - TIMER_W'(1);
               end
               for (int s = 0; s < MAX_ACTIVE; s++) begin
                  if (spawn && fsel[s]) begin
                     vld_n[s] = 1'b1;
                     idx_n[s] = rng_value;
                     tmr_n[s] = tout;
                  end
               end
               points_n = psum[POINTS_W] ? '1 :
                          psum[POINTS_W-1:0];
               // hits still score before a miss resets the streak
               if (n_exp != '0 || wrong) begin
                  streak_n = '0;
                  mult_n   = MULT_W'(1);
               end else if (n_hit != '0) begin
                  if (ssum >= STK_W'(STREAK_STEP)) begin
                     streak_n = ssum - STK_W'(STREAK_STEP);
                     mult_n   = mdbl;
                  end else begin
                     streak_n = ssum;
                  end
               end
               if (n_exp != '0) begin
                  if (int'(n_exp) >= int'(lives_left)) begin
                     lives_n = '0;
                     state_n = OVER;
                     vld_n   = '0;
                  end else begin
                     lives_n = lives_left - LIVE_W'(n_exp);
                  end
               end
            end
            default: begin
               if (start && level_sel != 2'd0) begin
                  state_n  = PLAY;
                  level_n  = level_sel;
                  points_n = '0;
                  streak_n = '0;
                  mult_n   = MULT_W'(1);
                  lives_n  = LIVE_W'(LIVES);
                  vld_n    = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      leds_n = '0;
      for (int s = 0; s < MAX_ACTIVE; s++)
         for (int i = 0; i < NUM_MOLES; i++)
            if (vld_n[s] && idx_n[s] == IDX_W'(i))
               leds_n[i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld          <= '0;
         mole_leds    <= '0;
         points       <= '0;
         lives_left   <= LIVE_W'(LIVES);
         multiplier   <= MULT_W'(1);
         level_number <= 2'd0;
         streak       <= '0;
         for (int s = 0; s < MAX_ACTIVE; s++) begin
            idx[s] <= '0;
            tmr[s] <= '0;
         end
      end else begin
         vld          <= vld_n;
         mole_leds    <= leds_n;
         points       <= points_n;
         lives_left   <= lives_n;
         multiplier   <= mult_n;
         level_number <= level_n;
         streak       <= streak_n;
         for (int s = 0; s < MAX_ACTIVE; s++) begin
            idx[s] <= idx_n[s];
            tmr[s] <= tmr_n[s];
         end
      end
   end

endmodule

// File: tb/tb_whac_a_mole_game_ctrl.sv
// tb_whac_a_mole_game_ctrl: directed bench for whac_a_mole_game_ctrl.
// Per-mole reference model compared every cycle plus literal checkpoints.
module tb_whac_a_mole_game_ctrl;

   localparam int NM   = 8;
   localparam int MA   = 2;
   localparam int LV   = 3;
   localparam int PW   = 5;
   localparam int TW   = 8;
   localparam int T1   = 20;
   localparam int T2   = 10;
   localparam int T3   = 30;
   localparam int STEP = 2;
   localparam int MM   = 4;
   localparam int IW   = 3;
   localparam int LW   = 2;
   localparam int MW   = 3;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          reset, start, abort, rng_valid;
   logic [1:0]    level_sel;
   logic [IW-1:0] rng_value;
   logic [NM-1:0] sw;
   logic          rng_req, playing, game_over;
   logic [NM-1:0] mole_leds;
   logic [PW-1:0] points;
   logic [LW-1:0] lives_left;
   logic [MW-1:0] multiplier;
   logic [1:0]    level_number;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   whac_a_mole_game_ctrl #(
      .NUM_MOLES(NM), .MAX_ACTIVE(MA), .LIVES(LV),
      .POINTS_W(PW), .TIMER_W(TW),
      .TIMEOUT_L1(T1), .TIMEOUT_L2(T2), .TIMEOUT_L3(T3),
      .STREAK_STEP(STEP), .MAX_MULT(MM)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .level_sel(level_sel), .abort(abort),
      .rng_value(rng_value), .rng_valid(rng_valid),
      .toggle_switches(sw), .rng_req(rng_req),
      .mole_leds(mole_leds), .points(points),
      .lives_left(lives_left), .multiplier(multiplier),
      .level_number(level_number), .playing(playing),
      .game_over(game_over)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_st;   // 0 idle, 1 play, 2 over
   bit [NM-1:0] m_lit;
   int          m_rem [NM];
   int          m_pts, m_lives, m_mult, m_lvl, m_streak;
   bit          m_init = 1'b0;
   bit [NM-1:0] h1 = '0, h2 = '0, h3 = '0;

   function automatic int capof(input int l);
      if (l == 1) return 1;
      if (l == 2) return (MA < 2) ? MA : 2;
      return MA;
   endfunction

   function automatic int toutof(input int l);
      if (l == 1) return T1;
      if (l == 2) return T2;
      return T3;
   endfunction

   function automatic int nlit(input bit [NM-1:0] v);
      int n = 0;
      for (int i = 0; i < NM; i++) n += int'(v[i]);
      return n;
   endfunction

   always @(posedge clk) begin
      bit [NM-1:0] tg, was;
      int nh, ne, old;
      bit wr, req;
      tg = h2 ^ h3;
      h3 = h2;
      h2 = h1;
      h1 = sw;
      m_init = 1'b1;
      if (reset) begin
         m_st = 0; m_lit = '0; m_pts = 0; m_lives = LV;
         m_mult = 1; m_lvl = 0; m_streak = 0;
      end else if (abort) begin
         m_st = 0; m_lit = '0;
      end else if (m_st == 1) begin
         was = m_lit;
         req = nlit(was) < capof(m_lvl);
         nh = 0; ne = 0; wr = 1'b0;
         for (int i = 0; i < NM; i++)
            if (tg[i]) begin
               if (was[i]) nh++;
               else wr = 1'b1;
            end
         for (int i = 0; i < NM; i++)
            if (was[i]) begin
               if (tg[i]) m_lit[i] = 1'b0;
               else if (m_rem[i] == 1) begin
                  m_lit[i] = 1'b0;
                  ne++;
               end else m_rem[i]--;
            end
         if (rng_valid && req && int'(rng_value) < NM &&
             !was[rng_value]) begin
            m_lit[rng_value] = 1'b1;
            m_rem[rng_value] = toutof(m_lvl);
         end
         m_pts = m_pts + nh * m_mult;
         if (m_pts > PMAX) m_pts = PMAX;
         if (ne > 0 || wr) begin
            m_streak = 0; m_mult = 1;
         end else if (nh > 0) begin
            old = m_streak;
            m_streak += nh;
            if (m_streak / STEP != old / STEP)
               m_mult = (m_mult * 2 > MM) ? MM : m_mult * 2;
         end
         m_lives = (ne >= m_lives) ? 0 : m_lives - ne;
         if (m_lives == 0) begin
            m_st = 2; m_lit = '0;
         end
      end else if (start && level_sel != 2'd0) begin
         m_st = 1; m_lvl = int'(level_sel); m_pts = 0;
         m_streak = 0; m_mult = 1; m_lives = LV; m_lit = '0;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("mdl_leds", int'(mole_leds), int'(m_lit));
         chk("mdl_points", int'(points), m_pts);
         chk("mdl_lives", int'(lives_left), m_lives);
         chk("mdl_mult", int'(multiplier), m_mult);
         chk("mdl_level", int'(level_number), m_lvl);
         chk("mdl_req", int'(rng_req),
             int'(m_st == 1 && nlit(m_lit) < capof(m_lvl)));
         chk("mdl_playing", int'(playing), int'(m_st == 1));
         chk("mdl_over", int'(game_over), int'(m_st == 2));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(input logic [1:0] l);
      level_sel = l;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      level_sel = 2'd0;
   endtask

   task automatic spawn(input int v);
      rng_value = IW'(v);
      rng_valid = 1'b1;
      @(negedge clk);
      rng_valid = 1'b0;
   endtask

   int n;
   int exp_mult [6] = '{1, 2, 2, 4, 4, 4};
   int exp_pts  [6] = '{1, 2, 4, 6, 10, 14};

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      rng_valid = 1'b0; rng_value = '0;
      level_sel = 2'd0; sw = '0;
      wait_n(3);
      chk("rst_leds", int'(mole_leds), 0);
      chk("rst_points", int'(points), 0);
      chk("rst_lives", int'(lives_left), 3);
      chk("rst_mult", int'(multiplier), 1);
      chk("rst_level", int'(level_number), 0);
      chk("rst_req", int'(rng_req), 0);
      chk("rst_playing", int'(playing), 0);
      chk("rst_over", int'(game_over), 0);
      reset = 1'b0;
      wait_n(1);

      // basic spawn and hit at level 1
      go(2'd1);
      chk("t1_playing", int'(playing), 1);
      chk("t1_req", int'(rng_req), 1);
      spawn(5);
      chk("t1_led", int'(mole_leds), 8'h20);
      chk("t1_req_full", int'(rng_req), 0);
      sw ^= 8'h20;
      wait_n(2);
      chk("t1_pts_early", int'(points), 0);
      wait_n(1);
      chk("t1_pts", int'(points), 1);
      chk("t1_led_clr", int'(mole_leds), 0);
      chk("t1_req_again", int'(rng_req), 1);

      // three expiries end the game
      for (int k = 0; k < 3; k++) begin
         spawn(k);
         n = 0;
         while (mole_leds != '0 && n < 40) begin
            n++;
            @(negedge clk);
         end
         chk("t2_life_len", n, T1);
         chk("t2_lives", int'(lives_left), 2 - k);
      end
      chk("t2_over", int'(game_over), 1);
      chk("t2_leds", int'(mole_leds), 0);
      chk("t2_pts_hold", int'(points), 1);

      // level 2 streak and multiplier saturation
      go(2'd2);
      chk("t3_pts_clr", int'(points), 0);
      chk("t3_lives", int'(lives_left), 3);
      chk("t3_level", int'(level_number), 2);
      for (int k = 0; k < 6; k++) begin
         spawn(k);
         sw ^= NM'(1 << k);
         wait_n(3);
         chk("t3_pts", int'(points), exp_pts[k]);
         chk("t3_mult", int'(multiplier), exp_mult[k]);
      end
      sw ^= 8'h80;
      wait_n(3);
      chk("t3_wrong_mult", int'(multiplier), 1);
      chk("t3_wrong_lives", int'(lives_left), 3);
      chk("t3_wrong_pts", int'(points), 14);

      // duplicate index discarded, capacity honoured
      spawn(3);
      spawn(3);
      chk("t4_dup_leds", int'(mole_leds), 8'h08);
      chk("t4_dup_req", int'(rng_req), 1);
      spawn(6);
      chk("t4_two_leds", int'(mole_leds), 8'h48);
      chk("t4_two_req", int'(rng_req), 0);
      spawn(7);
      chk("t4_no_third", int'(mole_leds), 8'h48);

      // simultaneous hits
      sw ^= 8'h48;
      wait_n(3);
      chk("t5_pair1_pts", int'(points), 16);
      chk("t5_pair1_mult", int'(multiplier), 2);
      spawn(4);
      spawn(1);
      chk("t5_pair2_leds", int'(mole_leds), 8'h12);
      sw ^= 8'h12;
      wait_n(3);
      chk("t5_pair2_pts", int'(points), 20);
      chk("t5_pair2_mult", int'(multiplier), 4);

      // hit landing exactly on the expiry cycle
      spawn(2);
      wait_n(7);
      sw ^= 8'h04;
      wait_n(3);
      chk("t5_edge_lives", int'(lives_left), 3);
      chk("t5_edge_pts", int'(points), 24);
      chk("t5_edge_leds", int'(mole_leds), 0);

      // one cycle too late: life lost
      spawn(2);
      wait_n(8);
      sw ^= 8'h04;
      wait_n(3);
      chk("t5_late_lives", int'(lives_left), 2);
      chk("t5_late_mult", int'(multiplier), 1);
      chk("t5_late_pts", int'(points), 24);

      // abort beats start
      spawn(0);
      abort = 1'b1;
      start = 1'b1;
      level_sel = 2'd3;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      level_sel = 2'd0;
      chk("t6_idle", int'(playing), 0);
      chk("t6_not_over", int'(game_over), 0);
      chk("t6_leds", int'(mole_leds), 0);
      chk("t6_pts", int'(points), 24);
      chk("t6_req", int'(rng_req), 0);
      go(2'd0);
      chk("t6_lvl0", int'(playing), 0);
      sw ^= 8'h01;
      wait_n(4);
      chk("t6_idle_tog", int'(points), 24);
      go(2'd3);
      chk("t6_play", int'(playing), 1);
      chk("t6_pts_clr", int'(points), 0);
      chk("t6_lives", int'(lives_left), 3);
      chk("t6_level", int'(level_number), 3);

      // score saturation at level 3
      for (int k = 0; k < 12; k++) begin
         spawn(k % NM);
         sw ^= NM'(1 << (k % NM));
         wait_n(3);
         if (k == 9) chk("t7_pts30", int'(points), 30);
      end
      chk("t7_sat", int'(points), PMAX);
      chk("t7_mult", int'(multiplier), 4);

      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_n(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
